mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 16: data bus width in bits.
REQ-002 Parameter ADDR_W, default 16: address bus width in bits.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for readyMEM; 0 disables the timeout.
REQ-004 Parameter ARB_MODE, default 0: 0 = fixed data-port priority, 1 = round-robin.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_req  in  1  instruction fetch request, held until inst_ack.
- inst_addr  in  ADDR_W  fetch address.
- inst_ack  out  1  one-cycle completion pulse.
- inst_data  out  DATA_W  fetched word, valid with inst_ack.
- data_req  in  1  data request, held until data_ack.
- data_we  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_ack  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  read word, valid with data_ack.
- err  out  1  timeout flag, valid with either ack.
- readMM  out  1  memory read strobe.
- writeMM  out  1  memory write strobe.
- addrBus  out  ADDR_W  memory address.
- dataBusOut  out  DATA_W  memory write data.
- dataBusIn  in  DATA_W  memory read data.
- readyMEM  in  1  memory completion.
- busy  out  1  high in any state other than IDLE.

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-007 In IDLE with any request pending, the unit SHALL grant one port and register the address, write data and direction, then enter ACCESS on the next edge.
REQ-008 The arbiter SHALL grant the data port when both ports request and ARB_MODE=0.
REQ-009 When both ports request and ARB_MODE=1, the arbiter SHALL grant the port not granted last; a lone requester SHALL always win.
REQ-010 In ACCESS, readMM (read) or writeMM (write) SHALL be high, with addrBus and dataBusOut held stable from the registered values.
REQ-011 readMM and writeMM SHALL never be high together.
REQ-012 When readyMEM is sampled high in ACCESS, the unit SHALL capture dataBusIn into the granted port's rdata register on reads, drop the strobe and enter RESP.
REQ-013 In RESP, the granted port's ack SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-014 Latency: a request sampled in IDLE at cycle N puts the strobe high at N+1; with readyMEM first high at N+1+k, ack SHALL be high at N+2+k. Minimum transaction length is 3 cycles.
REQ-015 The wait counter SHALL count ACCESS cycles with readyMEM low; width is clog2(TIMEOUT+1).
REQ-016 If the count reaches TIMEOUT (TIMEOUT>0), the unit SHALL abort: drop the strobe, enter RESP, and pulse ack with err=1 and rdata set to all zeros.
REQ-017 On normal completion, err SHALL be 0.
REQ-018 readyMEM SHALL be ignored outside ACCESS.
REQ-019 A req deasserted before its ack SHALL NOT cancel the transaction; the ack is still pulsed.
REQ-020 Requests SHALL NOT be sampled in ACCESS or RESP. Requesters drop req on the edge where ack is seen, so no stale re-grant occurs.
REQ-021 inst_data and data_rdata SHALL hold their last value between acks.

Reset
REQ-022 When rst is low, the state SHALL be IDLE and readMM, writeMM, inst_ack, data_ack, err and busy SHALL be 0, taking effect immediately and asynchronously.
REQ-023 During reset, addrBus, dataBusOut, inst_data, data_rdata and the wait counter SHALL be 0, and the round-robin pointer SHALL point to inst, so the first contested grant goes to data.
REQ-024 Reset during ACCESS SHALL drop the strobe without issuing an ack; the requester SHALL reissue.

Structure
REQ-025 Package mem_access_pkg SHALL hold the state enum, the constants ARB_FIXED=0 and ARB_RR=1, and the port-select encoding.
REQ-026 The two-way arbiter SHALL be a sub-module, mem_arbiter, containing the ARB_MODE logic and the last-grant pointer.

Verification
REQ-027 Data read: data_req=1, data_we=0, addr 0x0040; readyMEM high 2 cycles after readMM with dataBusIn=0xBEEF -> data_ack one cycle later, data_rdata=0xBEEF, err=0.
REQ-028 Write: data_we=1, addr 0x1234, wdata 0x5A5A -> writeMM=1, addrBus=0x1234, dataBusOut=0x5A5A held until readyMEM, then data_ack, and readMM stays 0 throughout.
REQ-029 Contention with ARB_MODE=0: both ports request continuously -> data port granted every transaction, inst starves. Same stimulus with ARB_MODE=1 -> grants alternate data, inst, data, inst.
REQ-030 Timeout with TIMEOUT=4: readyMEM held low -> strobe drops after 4 wait cycles, ack with err=1 and rdata=0x0000; next transaction completes with err=0.
REQ-031 Reset mid-access: rst low during ACCESS -> readMM=0 in the same cycle, no ack; after release, the unit is IDLE and busy=0.
REQ-032 Zero-wait: readyMEM high in the first ACCESS cycle -> ack at N+2, busy high exactly 2 cycles.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
// Imported by the arbiter and the top-level FSM.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_sel_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way arbiter between the instruction and data ports.
// Fixed data priority or round-robin on contention.
module mem_arbiter
    import mem_access_pkg::*;
#(
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      inst_req,
    input  logic      data_req,
    input  logic      grant_en,
    output port_sel_t gnt
);

    port_sel_t last_q;

    always_comb begin
        gnt = PORT_INST;
        unique case (1'b1)
            (inst_req && data_req): begin
                if (ARB_MODE == ARB_RR && last_q == PORT_DATA)
                    gnt = PORT_INST;
                else
                    gnt = PORT_DATA;
            end
            (data_req && !inst_req): gnt = PORT_DATA;
            default:                 gnt = PORT_INST;
        endcase
    end

    // Reset points at inst so the first contested grant goes to data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_q <= PORT_INST;
        else if (grant_en)
            last_q <= gnt;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Shares one memory bus between an instruction and a data port.
// IDLE grants a port, ACCESS drives the strobe, RESP pulses ack.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 255,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ack,
    output logic [DATA_W-1:0] inst_data,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              err,
    output logic              readMM,
    output logic              writeMM,
    output logic [ADDR_W-1:0] addrBus,
    output logic [DATA_W-1:0] dataBusOut,
    input  logic [DATA_W-1:0] dataBusIn,
    input  logic              readyMEM,
    output logic              busy
);

    localparam bit TO_EN = (TIMEOUT > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST  = TO_EN ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

    state_t            state_q, state_d;
    port_sel_t         sel_q, gnt;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, inst_data_q, data_rdata_q;
    logic [CNT_W-1:0]  wait_q;
    logic              any_req, start, done, timeout;

    assign any_req = inst_req | data_req;
    assign start   = (state_q == IDLE) && any_req;
    assign done    = (state_q == ACCESS) && readyMEM;
    // Abort on the edge where the wait count would reach TIMEOUT.
    assign timeout = TO_EN && (state_q == ACCESS) && !readyMEM
                     && (wait_q == CNT_LAST);

    mem_arbiter #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .inst_req (inst_req),
        .data_req (data_req),
        .grant_en (start),
        .gnt      (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (readyMEM || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q        <= PORT_INST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_q       <= '0;
            err_q        <= 1'b0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            if (start) begin
                sel_q <= gnt;
                if (gnt == PORT_DATA) begin
                    addr_q  <= data_addr;
                    wdata_q <= data_wdata;
                    we_q    <= data_we;
                end else begin
                    addr_q  <= inst_addr;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                end
            end

            if (state_q == ACCESS && !readyMEM)
                wait_q <= wait_q + CNT_W'(1);
            else
                wait_q <= '0;

            if (done) begin
                err_q <= 1'b0;
                if (!we_q) begin
                    if (sel_q == PORT_DATA)
                        data_rdata_q <= dataBusIn;
                    else
                        inst_data_q <= dataBusIn;
                end
            end else if (timeout) begin
                err_q <= 1'b1;
                if (sel_q == PORT_DATA)
                    data_rdata_q <= '0;
                else
                    inst_data_q <= '0;
            end
        end
    end

    assign readMM     = (state_q == ACCESS) && !we_q;
    assign writeMM    = (state_q == ACCESS) && we_q;
    assign addrBus    = addr_q;
    assign dataBusOut = wdata_q;
    assign inst_ack   = (state_q == RESP) && (sel_q == PORT_INST);
    assign data_ack   = (state_q == RESP) && (sel_q == PORT_DATA);
    assign err        = (state_q == RESP) && err_q;
    assign busy       = (state_q != IDLE);
    assign inst_data  = inst_data_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: u0 fixed priority, u1 round-robin, both TIMEOUT=4.
// Both share the same stimulus; timing is identical in both.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [15:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] data_wdata = '0;
    logic [15:0] dataBusIn = '0;
    logic        readyMEM = 1'b0;

    logic        inst_ack0, data_ack0, err0, rd0, wr0, busy0;
    logic [15:0] inst_data0, data_rdata0, addr0, dout0;
    logic        inst_ack1, data_ack1, err1, rd1, wr1, busy1;
    logic [15:0] inst_data1, data_rdata1, addr1, dout1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_W(16), .ADDR_W(16), .TIMEOUT(4), .ARB_MODE(0)
    ) u0 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack0), .inst_data(inst_data0),
        .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack0), .data_rdata(data_rdata0),
        .err(err0), .readMM(rd0), .writeMM(wr0),
        .addrBus(addr0), .dataBusOut(dout0),
        .dataBusIn(dataBusIn), .readyMEM(readyMEM), .busy(busy0)
    );

    mem_access_unit #(
        .DATA_W(16), .ADDR_W(16), .TIMEOUT(4), .ARB_MODE(1)
    ) u1 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack1), .inst_data(inst_data1),
        .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack1), .data_rdata(data_rdata1),
        .err(err1), .readMM(rd1), .writeMM(wr1),
        .addrBus(addr1), .dataBusOut(dout1),
        .dataBusIn(dataBusIn), .readyMEM(readyMEM), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_wr", wr0, 0);
        chk("rst_acks", {inst_ack0, data_ack0, err0}, 0);
        chk("rst_addr", addr0, 16'h0000);
        chk("rst_dout", dout0, 16'h0000);
        chk("rst_rdata", data_rdata0, 16'h0000);
        chk("rst_idata", inst_data0, 16'h0000);
        rst = 1'b1;
        tick();

        // data read, readyMEM two cycles after readMM
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0040;
        tick();
        chk("rd_strobe", rd0, 1);
        chk("rd_wr_low", wr0, 0);
        chk("rd_addr", addr0, 16'h0040);
        chk("rd_busy", busy0, 1);
        tick();
        chk("rd_hold", rd0, 1);
        chk("rd_noack", data_ack0, 0);
        tick();
        readyMEM = 1'b1; dataBusIn = 16'hBEEF;
        tick();
        chk("rd_ack", data_ack0, 1);
        chk("rd_iack", inst_ack0, 0);
        chk("rd_data", data_rdata0, 16'hBEEF);
        chk("rd_err", err0, 0);
        chk("rd_drop", rd0, 0);
        data_req = 1'b0; readyMEM = 1'b0;
        tick();
        chk("rd_ack_1cyc", data_ack0, 0);
        chk("rd_idle", busy0, 0);
        chk("rd_keep", data_rdata0, 16'hBEEF);

        // write; req dropped early must not cancel
        data_req = 1'b1; data_we = 1'b1;
        data_addr = 16'h1234; data_wdata = 16'h5A5A;
        tick();
        chk("wr_strobe", wr0, 1);
        chk("wr_rd_low", rd0, 0);
        chk("wr_addr", addr0, 16'h1234);
        chk("wr_dout", dout0, 16'h5A5A);
        data_req = 1'b0; data_addr = 16'h0000; data_wdata = 16'h0000;
        tick();
        chk("wr_hold", wr0, 1);
        chk("wr_rd_low2", rd0, 0);
        chk("wr_addr_hold", addr0, 16'h1234);
        chk("wr_dout_hold", dout0, 16'h5A5A);
        readyMEM = 1'b1;
        tick();
        chk("wr_ack", data_ack0, 1);
        chk("wr_err", err0, 0);
        chk("wr_drop", wr0, 0);
        chk("wr_rdata_keep", data_rdata0, 16'hBEEF);
        data_we = 1'b0;
        tick();
        chk("wr_idle", busy0, 0);

        // readyMEM high in IDLE is ignored
        tick();
        chk("ign_busy", busy0, 0);
        chk("ign_ack", {inst_ack0, data_ack0}, 0);

        // zero-wait inst fetch: ack at N+2, busy 2 cycles
        inst_req = 1'b1; inst_addr = 16'h0100; dataBusIn = 16'h1111;
        tick();
        chk("zw_busy1", busy0, 1);
        chk("zw_rd", rd0, 1);
        chk("zw_addr", addr0, 16'h0100);
        inst_req = 1'b0;
        tick();
        chk("zw_busy2", busy0, 1);
        chk("zw_iack", inst_ack0, 1);
        chk("zw_dack", data_ack0, 0);
        chk("zw_idata", inst_data0, 16'h1111);
        chk("zw_err", err0, 0);
        readyMEM = 1'b0;
        tick();
        chk("zw_busy3", busy0, 0);
        chk("zw_ack_off", inst_ack0, 0);

        // timeout after 4 wait cycles
        data_req = 1'b1; data_addr = 16'h0200; dataBusIn = 16'hFFFF;
        tick();
        chk("to_rd1", rd0, 1);
        data_req = 1'b0;
        tick();
        tick();
        tick();
        chk("to_rd4", rd0, 1);
        chk("to_noack", data_ack0, 0);
        tick();
        chk("to_drop", rd0, 0);
        chk("to_ack", data_ack0, 1);
        chk("to_err", err0, 1);
        chk("to_rdata", data_rdata0, 16'h0000);
        tick();
        chk("to_idle", busy0, 0);
        chk("to_err_off", err0, 0);
        inst_req = 1'b1; inst_addr = 16'h0300;
        readyMEM = 1'b1; dataBusIn = 16'h2222;
        tick();
        inst_req = 1'b0;
        tick();
        chk("to_next_ack", inst_ack0, 1);
        chk("to_next_err", err0, 0);
        chk("to_next_data", inst_data0, 16'h2222);
        readyMEM = 1'b0;
        tick();

        // reset in the middle of ACCESS
        data_req = 1'b1; data_addr = 16'h0400;
        tick();
        chk("mr_rd", rd0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_rd_drop", rd0, 0);
        chk("mr_busy", busy0, 0);
        chk("mr_ack", {inst_ack0, data_ack0, err0}, 0);
        chk("mr_addr", addr0, 16'h0000);
        data_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mr_idle", busy0, 0);
        chk("mr_noack", {inst_ack0, data_ack0}, 0);

        // contention: u0 always data, u1 alternates data/inst
        inst_req = 1'b1; inst_addr = 16'h0500;
        data_req = 1'b1; data_addr = 16'h0600; data_we = 1'b0;
        readyMEM = 1'b1; dataBusIn = 16'h3333;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            chk($sformatf("fx_dack%0d", i), data_ack0, 1);
            chk($sformatf("fx_iack%0d", i), inst_ack0, 0);
            chk($sformatf("rr_dack%0d", i), data_ack1,
                ((i % 2) == 0) ? 16'd1 : 16'd0);
            chk($sformatf("rr_iack%0d", i), inst_ack1,
                ((i % 2) == 1) ? 16'd1 : 16'd0);
            tick();
        end
        inst_req = 1'b0; data_req = 1'b0; readyMEM = 1'b0;
        tick();
        tick();
        chk("end_idle0", busy0, 0);
        chk("end_idle1", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
